dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data port: services load/store requests (address, write data, byte enables) from the core or its bus adapter.
- Models a word-organised RAM with a configurable fixed wait-state latency and a valid/ready handshake on both the request and response channels.
- Sits between the core's ALUResult/WriteData/MemWrite outputs (via adapter) and the ReadData return path.
- Gives the multi-cycle and pipelined cores a realistic, stallable memory target.

Parameters:
- DEPTH, 1024, number of 32-bit words; legal byte addresses are 0 to 4*DEPTH-1.
- WAIT_STATES, 2, extra cycles between request acceptance and response (legal range 0..15).
- ADDR_W, 32, request address width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i enables bits 8i+7:8i (little-endian).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errored requests.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high, with priority over all other activity.
  - Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Memory contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1, driven combinationally from state. On req_valid&&req_ready, latch we, addr, wdata and be.
    - If WAIT_STATES==0, go to RESP.
    - Otherwise go to WAIT with counter=WAIT_STATES-1.
  - WAIT: req_ready=0. Counter decrements each cycle. When counter==0, go to RESP at the next edge.
  - RESP: req_ready=0, rsp_valid=1. On rsp_valid&&rsp_ready, go to IDLE.
- Latency:
  - A request accepted at the end of cycle 0 gives rsp_valid=1 from cycle 1+WAIT_STATES.
  - WAIT lasts exactly WAIT_STATES cycles.
  - Maximum throughput is one transaction per 2+WAIT_STATES cycles; there are no back-to-back accepts.
- Commit:
  - The memory access happens on the edge entering RESP.
  - Load: rsp_rdata is registered with mem[addr>>2] at that edge.
  - Store: only the enabled byte lanes are written; rsp_rdata=0.
  - req_be=0 on a store completes normally and leaves memory unchanged.
  - req_be is ignored on loads.
- Error handling:
  - rsp_err=1 if addr[1:0]!=0 or addr[ADDR_W-1:2]>=DEPTH.
  - An errored request performs no write and returns rsp_rdata=0.
  - Errored requests still complete the full WAIT and RESP sequence with identical timing.
- Stability:
  - While in RESP with rsp_ready=0, rsp_valid, rsp_rdata and rsp_err hold constant.
  - All request inputs are ignored outside IDLE.
  - rsp_ready is ignored outside RESP.
- Reset mid-operation:
  - Reset abandons the in-flight transaction, and no response is issued.
  - If reset coincides with the commit edge, the store is NOT performed.
- Deassert rsp_valid and clear rsp_err/rsp_rdata on the edge leaving RESP.

Test Plan:
1. WAIT_STATES=2: store 0xDEADBEEF to 0x10 with be=1111, accepted in cycle 0 -> rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0. Then load 0x10 -> rsp_rdata=0xDEADBEEF in cycle 3 after its accept.
2. Byte enables: store 0x11223344 with be=0101 to 0x10 holding 0xDEADBEEF -> a load of 0x10 returns 0xDE22BE44.
3. Errors:
   - Load 0x13 -> rsp_err=1, rsp_rdata=0, same latency as a legal access.
   - Store 0xFFFFFFFF to 0x1000 (DEPTH=1024) -> rsp_err=1; a load of 0x0 afterwards shows its prior value unchanged.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP while driving req_valid=1 -> rsp_valid/rsp_rdata/rsp_err stable, req_ready=0, and no new request is accepted. Raise rsp_ready -> IDLE and req_ready=1 the next cycle.
5. Reset in WAIT during a store of 0xCAFEF00D to 0x20 (previously 0x00000005) -> all outputs return to reset values, rsp_valid never asserts, and a later load of 0x20 returns 0x00000005.
6. WAIT_STATES=0 instance, rsp_ready tied to 1, req_valid held high with 4 loads -> each rsp_valid arrives 1 cycle after its accept, with accepts every 2 cycles (cycles 0, 2, 4, 6).

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-organised data RAM with fixed wait-state latency and
//               valid/ready handshakes on both request and response channels.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int                c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] c_DEPTH     = ADDR_W'(DEPTH);
    localparam logic [3:0]        c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_commit;
    logic              w_c_we;
    logic [ADDR_W-1:0] w_c_addr;
    logic [31:0]       w_c_wdata;
    logic [3:0]        w_c_be;
    logic [ADDR_W-1:0] w_word;
    logic              w_err;
    logic [c_IDX_W-1:0] w_idx;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // With zero wait states the commit happens on the accept edge itself,
    // so the access must use the live request rather than the latched copy.
    assign w_c_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_c_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_c_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_c_be    = (r_state == S_IDLE) ? req_be    : r_be;

    assign w_word = {2'b00, w_c_addr[ADDR_W-1:2]};
    assign w_err  = (w_c_addr[1:0] != 2'b00) || (w_word >= c_DEPTH);
    assign w_idx  = w_word[c_IDX_W-1:0];

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_next   = S_RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next   = S_RESP;
                    w_commit = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= c_WAIT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (!w_c_we && !w_err) ? r_mem[w_idx] : 32'd0;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= 32'd0;
            end
        end
    end

    // Storage is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_c_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_c_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
